cpu_sequencer: RTL

Top-level instruction sequencer for the Harvard MIPS core. It drives the `state` strobe that advances the program counter and gates register write-back. It sequences each instruction through fetch, optional data-memory wait and execute, and stalls on instruction/data memory wait requests. It halts the core when the PC block raises `finish`.

---
 rtl/cpu_seq_pkg.sv | 15 +
 rtl/cpu_sequencer_wait_timer.sv | 31 +++
 rtl/cpu_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types for the MIPS instruction sequencer.
// State encoding and perf-counter width.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_MEMWAIT = 3'd2,
    S_EXEC    = 3'd3,
    S_HALTED  = 3'd4
  } seq_state_t;

  localparam int SEQ_CNT_W = 32;

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Consecutive wait-cycle counter with MAX_WAIT compare.
// MAX_WAIT = 0 pins the count at 0 and never expires.
module wait_timer #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int CW =
    (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);
  localparam bit ENABLED = (MAX_WAIT != 0);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt_q <= '0;
    end else if (count_en && cnt_q != LIMIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = ENABLED && count_en
                && (cnt_q == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: FETCH -> [MEMWAIT] -> EXEC, halts on finish.
// CPU_SEQ_PERF_COUNTERS_EN adds cycle_count / instr_count ports.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic imem_waitrequest,
  input  logic mem_access,
  input  logic dmem_waitrequest,
  input  logic finish,
  output logic state,
  output logic imem_read,
  output logic dmem_en,
  output logic reg_write_en,
  output logic active,
  output logic timeout
`ifdef CPU_SEQ_PERF_COUNTERS_EN
  ,
  output logic [SEQ_CNT_W-1:0] cycle_count,
  output logic [SEQ_CNT_W-1:0] instr_count
`endif
);

  seq_state_t st_q;
  seq_state_t st_d;
  logic count_en;
  logic clear;
  logic expired;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE: st_d = S_FETCH;
      S_FETCH: begin
        if (finish || expired) begin
          st_d = S_HALTED;
        end else if (!imem_waitrequest) begin
          st_d = mem_access ? S_MEMWAIT : S_EXEC;
        end
      end
      S_MEMWAIT: begin
        if (expired) begin
          st_d = S_HALTED;
        end else if (!dmem_waitrequest) begin
          st_d = S_EXEC;
        end
      end
      S_EXEC:   st_d = S_FETCH;
      S_HALTED: st_d = S_HALTED;
      default:  st_d = S_IDLE;
    endcase
  end

  // Only an unbroken run of wait cycles in one state counts.
  assign count_en =
    (st_q == S_FETCH   && imem_waitrequest) ||
    (st_q == S_MEMWAIT && dmem_waitrequest);
  assign clear = (st_d != st_q) || !count_en;

  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .count_en (count_en),
    .clear    (clear),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q    <= S_IDLE;
      timeout <= 1'b0;
    end else begin
      st_q <= st_d;
      if (expired) begin
        timeout <= 1'b1;
      end
    end
  end

  assign imem_read    = (st_q == S_FETCH);
  assign dmem_en      = (st_q == S_MEMWAIT);
  assign state        = (st_q == S_EXEC);
  assign reg_write_en = state;
  assign active       = imem_read | dmem_en | state;

`ifdef CPU_SEQ_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (active) begin
        cycle_count <= cycle_count + 1'b1;
      end
      if (state) begin
        instr_count <= instr_count + 1'b1;
      end
    end
  end
`endif

endmodule
